// File: rtl/alarm_indicator_driver.sv
// Alarm output stage: turns 1-cycle match/dismiss pulses into a blinking LED and a gated buzzer
// tone, with a ring timeout and a post-alarm re-trigger lockout.
module alarm_indicator_driver #(
   parameter int unsigned TICK_DIV          = 50_000_000,
   parameter int unsigned TONE_DIV          = 50_000,
   parameter int unsigned RING_HALF_PERIODS = 120,
   parameter int unsigned HOLD_HALF_PERIODS = 120
) (
   input  logic clk_in,
   input  logic rst,
   input  logic en,
   input  logic trigger,
   input  logic dismiss,
   output logic led,
   output logic buzzer,
   output logic active,
   output logic timeout_p
);

   localparam int unsigned HALF_MAX = (RING_HALF_PERIODS > HOLD_HALF_PERIODS) ?
                                      RING_HALF_PERIODS : HOLD_HALF_PERIODS;
   localparam int unsigned TICK_W   = $clog2(TICK_DIV);
   localparam int unsigned TONE_W   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam int unsigned HALF_W   = $clog2(HALF_MAX + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RING = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
   logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
   logic                tone_q, tone_d;
   logic                led_q, led_d;
   logic                buzzer_q, buzzer_d;
   logic                active_q, active_d;
   logic                timeout_q, timeout_d;

   logic                tick_wrap, tone_wrap;
   logic [TICK_W-1:0]   tick_inc;
   logic [TONE_W-1:0]   tone_inc;
   logic [HALF_W-1:0]   half_inc;

   // State and output registers
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         tone_cnt_q <= '0;
         half_cnt_q <= '0;
         tone_q     <= 1'b0;
         led_q      <= 1'b0;
         buzzer_q   <= 1'b0;
         active_q   <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         tone_cnt_q <= tone_cnt_d;
         half_cnt_q <= half_cnt_d;
         tone_q     <= tone_d;
         led_q      <= led_d;
         buzzer_q   <= buzzer_d;
         active_q   <= active_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next state and outputs; every default clears counters and drives outputs low
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = '0;
      tone_cnt_d = '0;
      half_cnt_d = '0;
      tone_d     = 1'b0;
      led_d      = 1'b0;
      buzzer_d   = 1'b0;
      active_d   = 1'b0;
      timeout_d  = 1'b0;

      tick_wrap = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
      tone_wrap = (tone_cnt_q == TONE_W'(TONE_DIV - 1));
      tick_inc  = tick_cnt_q + TICK_W'(1);
      tone_inc  = tone_cnt_q + TONE_W'(1);
      half_inc  = half_cnt_q + HALF_W'(1);

      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d  = RING;
                  led_d    = 1'b1;
                  active_d = 1'b1;
               end
            end
            RING: begin
               // Dismiss outranks the timeout, so a coincident final tick emits no pulse
               if (dismiss) begin
                  state_d = HOLD;
               end else if (tick_wrap && (half_inc == HALF_W'(RING_HALF_PERIODS))) begin
                  state_d   = HOLD;
                  timeout_d = 1'b1;
               end else begin
                  active_d   = 1'b1;
                  tick_cnt_d = tick_wrap ? '0 : tick_inc;
                  tone_cnt_d = tone_wrap ? '0 : tone_inc;
                  half_cnt_d = tick_wrap ? half_inc : half_cnt_q;
                  tone_d     = tone_wrap ? ~tone_q : tone_q;
                  led_d      = tick_wrap ? ~led_q : led_q;
                  buzzer_d   = tone_d & led_d;
               end
            end
            HOLD: begin
               if (tick_wrap && (half_inc == HALF_W'(HOLD_HALF_PERIODS))) begin
                  state_d = IDLE;
               end else begin
                  tick_cnt_d = tick_wrap ? '0 : tick_inc;
                  half_cnt_d = tick_wrap ? half_inc : half_cnt_q;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign led       = led_q;
   assign buzzer    = buzzer_q;
   assign active    = active_q;
   assign timeout_p = timeout_q;

endmodule

// File: tb/tb_alarm_indicator_driver.sv
// Directed bench for alarm_indicator_driver with short blink/tone/ring/hold periods.
module tb_alarm_indicator_driver;

   logic clk_in;
   logic rst;
   logic en;
   logic trigger;
   logic dismiss;
   logic led;
   logic buzzer;
   logic active;
   logic timeout_p;

   int n_chk;
   int n_bad;

   alarm_indicator_driver #(
      .TICK_DIV          (4),
      .TONE_DIV          (2),
      .RING_HALF_PERIODS (6),
      .HOLD_HALF_PERIODS (3)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en),
      .trigger   (trigger),
      .dismiss   (dismiss),
      .led       (led),
      .buzzer    (buzzer),
      .active    (active),
      .timeout_p (timeout_p)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One active edge; returns at the following falling edge where outputs are sampled
   task automatic cyc();
      @(negedge clk_in);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".led"},     32'(led),       32'd0);
      chk({tag, ".buzzer"},  32'(buzzer),    32'd0);
      chk({tag, ".active"},  32'(active),    32'd0);
      chk({tag, ".timeout"}, 32'(timeout_p), 32'd0);
   endtask

   // Expected outputs k edges after the RING entry edge (4-cycle blink, 2-cycle tone, 24-cycle ring)
   task automatic chk_ring(input string tag, input int k);
      logic e_led, e_buz, e_act, e_to;
      if (k < 24) begin
         e_led = ((k / 4) % 2) == 0;
         e_buz = e_led && (((k / 2) % 2) == 1);
         e_act = 1'b1;
         e_to  = 1'b0;
      end else begin
         e_led = 1'b0;
         e_buz = 1'b0;
         e_act = 1'b0;
         e_to  = (k == 24);
      end
      chk($sformatf("%s.led[%0d]", tag, k),     32'(led),       32'(e_led));
      chk($sformatf("%s.buzzer[%0d]", tag, k),  32'(buzzer),    32'(e_buz));
      chk($sformatf("%s.active[%0d]", tag, k),  32'(active),    32'(e_act));
      chk($sformatf("%s.timeout[%0d]", tag, k), 32'(timeout_p), 32'(e_to));
   endtask

   initial begin
      n_chk   = 0;
      n_bad   = 0;
      rst     = 1'b0;
      en      = 1'b0;
      trigger = 1'b0;
      dismiss = 1'b0;

      // Reset state
      cyc();
      cyc();
      chk_idle("reset");
      rst = 1'b1;
      en  = 1'b1;

      // Idle with no trigger, then full ring to timeout
      repeat (9) cyc();
      chk_idle("idle");
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      chk_ring("ringA", 0);
      for (int k = 1; k <= 24; k++) begin
         cyc();
         chk_ring("ringA", k);
      end
      cyc();
      chk_idle("holdA_25");
      for (int k = 26; k <= 35; k++) cyc();
      // Last HOLD cycle ignores trigger, first IDLE cycle accepts it
      trigger = 1'b1;
      cyc();
      chk("holdA_last_trig.active", 32'(active), 32'd0);
      cyc();
      trigger = 1'b0;
      chk("rearmA.active", 32'(active), 32'd1);
      chk("rearmA.led",    32'(led),    32'd1);

      // en=0 mid-RING forces IDLE, trigger re-arms right away
      cyc();
      cyc();
      en = 1'b0;
      cyc();
      chk_idle("en_off");
      en      = 1'b1;
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      chk_ring("rearmB", 0);

      // Dismiss 5 cycles after trigger, then 12-cycle lockout
      repeat (4) cyc();
      dismiss = 1'b1;
      cyc();
      dismiss = 1'b0;
      chk_idle("dismiss");
      for (int i = 0; i < 12; i++) begin
         trigger = 1'b1;
         cyc();
         chk($sformatf("lockout[%0d].active", i), 32'(active), 32'd0);
      end
      trigger = 1'b1;
      dismiss = 1'b1;
      cyc();
      trigger = 1'b0;
      dismiss = 1'b0;
      chk_ring("trig_dis_idle", 0);

      // Dismiss coincident with the final tick suppresses timeout_p
      for (int k = 1; k <= 23; k++) begin
         cyc();
         chk_ring("ringD", k);
      end
      dismiss = 1'b1;
      cyc();
      dismiss = 1'b0;
      chk_idle("dis_final_tick");
      cyc();
      chk("dis_final_tick_next.timeout", 32'(timeout_p), 32'd0);
      repeat (11) cyc();

      // en=0 blocks trigger
      en      = 1'b0;
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      chk("en_off_trig.active", 32'(active), 32'd0);
      en = 1'b1;
      cyc();
      chk("en_on_idle.active", 32'(active), 32'd0);

      // Asynchronous reset mid-RING
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      chk("ringE.active", 32'(active), 32'd1);
      repeat (3) cyc();
      #2 rst = 1'b0;
      #1 chk_idle("async_rst");
      cyc();
      chk_idle("rst_held");
      rst = 1'b1;
      cyc();
      chk_idle("rst_released");

      // Repeat trigger during RING must not restart timing
      trigger = 1'b1;
      cyc();
      trigger = 1'b0;
      chk_ring("ringF", 0);
      for (int k = 1; k <= 24; k++) begin
         trigger = (k == 7) || (k == 13);
         cyc();
         chk_ring("ringF", k);
      end
      trigger = 1'b0;
      cyc();
      chk("ringF_25.timeout", 32'(timeout_p), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
